// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg : shared widths, write-FSM states and a saturating-increment helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package axis_pkg;

   localparam int AXIS_W128 = 128;
   localparam int STAT_W    = 32;

   typedef enum logic [0:0] {
      WR_ACCEPT  = 1'b0,
      WR_DISCARD = 1'b1
   } wr_state_t;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + STAT_W'(1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/axis_pkt_fifo_mem.sv
// ---------------------------------------------------------------------------
// axis_pkt_fifo_mem : simple dual-port RAM, synchronous write, async read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_pkt_fifo_mem #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH),
   parameter int W     = 129
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/axis_pkt_fifo_128.sv
// ---------------------------------------------------------------------------
// axis_pkt_fifo_128 : store-and-forward 128-bit AXIS packet FIFO, drops whole
// packets on overflow. Optional stats ports under AXIS_PKT_FIFO_STATS_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_pkt_fifo_128
   import axis_pkg::*;
#(
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [AXIS_W128-1:0] s_axis_tdata,
   input  logic                 s_axis_tlast,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [AXIS_W128-1:0] m_axis_tdata,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [AW:0]          fill_level,
   output logic [AW:0]          pkt_avail,
`ifdef AXIS_PKT_FIFO_STATS_EN
   output logic [STAT_W-1:0]    drop_count,
   output logic [STAT_W-1:0]    pkt_out_count,
`endif
   output logic                 drop_pulse
);

   logic [AW:0]          wr_ptr;
   logic [AW:0]          commit_ptr;
   logic [AW:0]          rd_ptr;
   logic [AW:0]          wr_ptr_nx;
   logic [AW:0]          commit_ptr_nx;
   logic [AW:0]          occupancy;
   wr_state_t            state;
   wr_state_t            state_nx;
   logic                 accept;
   logic                 full;
   logic                 mem_we;
   logic                 commit_ev;
   logic                 drop_nx;
   logic                 load;
   logic                 out_last;
   logic [AXIS_W128:0]   rd_word;

   assign accept   = s_axis_tvalid & s_axis_tready;
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign load     = (rd_ptr != commit_ptr) && (!m_axis_tvalid || m_axis_tready);
   assign out_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // The beat parked in the output register still counts until handed off.
   assign occupancy  = wr_ptr - rd_ptr;
   assign fill_level = occupancy + {{AW{1'b0}}, m_axis_tvalid};

   axis_pkt_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (AXIS_W128 + 1)
   ) u_mem (
      .clk   (aclk),
      .we    (mem_we),
      .waddr (wr_ptr[AW-1:0]),
      .wdata ({s_axis_tlast, s_axis_tdata}),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_word)
   );

   always_comb begin
      state_nx      = state;
      wr_ptr_nx     = wr_ptr;
      commit_ptr_nx = commit_ptr;
      mem_we        = 1'b0;
      commit_ev     = 1'b0;
      drop_nx       = 1'b0;
      if (accept) begin
         case (state)
            WR_ACCEPT: begin
               if (!full) begin
                  mem_we    = 1'b1;
                  wr_ptr_nx = wr_ptr + (AW+1)'(1);
                  if (s_axis_tlast) begin
                     commit_ptr_nx = wr_ptr + (AW+1)'(1);
                     commit_ev     = 1'b1;
                  end
               end else begin
                  // Rewind over the partial packet; skip its tail if any.
                  wr_ptr_nx = commit_ptr;
                  drop_nx   = 1'b1;
                  if (!s_axis_tlast) begin
                     state_nx = WR_DISCARD;
                  end
               end
            end
            WR_DISCARD: begin
               if (s_axis_tlast) begin
                  state_nx = WR_ACCEPT;
               end
            end
            default: state_nx = WR_ACCEPT;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= WR_ACCEPT;
         wr_ptr        <= '0;
         commit_ptr    <= '0;
         drop_pulse    <= 1'b0;
         s_axis_tready <= 1'b0;
      end else begin
         state         <= state_nx;
         wr_ptr        <= wr_ptr_nx;
         commit_ptr    <= commit_ptr_nx;
         drop_pulse    <= drop_nx;
         s_axis_tready <= 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_ptr        <= '0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
      end else if (load) begin
         rd_ptr        <= rd_ptr + (AW+1)'(1);
         m_axis_tdata  <= rd_word[AXIS_W128-1:0];
         m_axis_tlast  <= rd_word[AXIS_W128];
         m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pkt_avail <= '0;
      end else begin
         case ({commit_ev, out_last})
            2'b10:   pkt_avail <= pkt_avail + (AW+1)'(1);
            2'b01:   pkt_avail <= pkt_avail - (AW+1)'(1);
            default: pkt_avail <= pkt_avail;
         endcase
      end
   end

`ifdef AXIS_PKT_FIFO_STATS_EN
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         drop_count    <= '0;
         pkt_out_count <= '0;
      end else begin
         if (drop_nx) begin
            drop_count <= sat_inc(drop_count);
         end
         if (out_last) begin
            pkt_out_count <= sat_inc(pkt_out_count);
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_pkt_fifo_128.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_fifo_128 : directed + random stimulus against a queue-based model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axis_pkt_fifo_128;

   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [127:0]  s_axis_tdata = '0;
   logic          s_axis_tlast = 1'b0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [127:0]  m_axis_tdata;
   logic          m_axis_tlast;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic [AW:0]   fill_level;
   logic [AW:0]   pkt_avail;
   logic          drop_pulse;
`ifdef AXIS_PKT_FIFO_STATS_EN
   logic [31:0]   drop_count;
   logic [31:0]   pkt_out_count;
`endif

   always #5 aclk = ~aclk;

   axis_pkt_fifo_128 #(.DEPTH(DEPTH)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .fill_level    (fill_level),
      .pkt_avail     (pkt_avail),
`ifdef AXIS_PKT_FIFO_STATS_EN
      .drop_count    (drop_count),
      .pkt_out_count (pkt_out_count),
`endif
      .drop_pulse    (drop_pulse)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   // ---------------- behavioural model: queues of beats ----------------
   typedef struct packed {
      logic         l;
      logic [127:0] d;
   } beat_t;

   beat_t pend[$];
   beat_t comq[$];
   beat_t m_out = '0;
   bit    m_ov = 1'b0;
   bit    m_discard = 1'b0;
   bit    m_ready = 1'b0;
   bit    m_drop = 1'b0;
   int    m_pkt = 0;
   int    m_drops = 0;
   int    m_outs = 0;
   int    occ;
   bit    acc;
   bit    do_load;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pend.delete();
         comq.delete();
         m_out = '0;
         m_ov = 1'b0;
         m_discard = 1'b0;
         m_ready = 1'b0;
         m_drop = 1'b0;
         m_pkt = 0;
         m_drops = 0;
         m_outs = 0;
      end else begin
         occ = pend.size() + comq.size();
         acc = s_axis_tvalid && m_ready;
         if (m_ov && m_axis_tready && m_out.l) begin
            m_pkt--;
            m_outs++;
         end
         do_load = (comq.size() > 0) && (!m_ov || m_axis_tready);
         m_drop = 1'b0;
         if (acc) begin
            if (m_discard) begin
               if (s_axis_tlast) m_discard = 1'b0;
            end else if (occ < DEPTH) begin
               pend.push_back('{l: s_axis_tlast, d: s_axis_tdata});
               if (s_axis_tlast) begin
                  foreach (pend[i]) comq.push_back(pend[i]);
                  pend.delete();
                  m_pkt++;
               end
            end else begin
               m_drop = 1'b1;
               m_drops++;
               pend.delete();
               if (!s_axis_tlast) m_discard = 1'b1;
            end
         end
         if (do_load) begin
            m_out = comq.pop_front();
            m_ov  = 1'b1;
         end else if (m_axis_tready) begin
            m_ov = 1'b0;
         end
         m_ready = 1'b1;
      end
   end

   always @(negedge aclk) begin
      if (chk_en) begin
         chk("m_tvalid", 128'(m_axis_tvalid), 128'(m_ov));
         if (m_ov) begin
            chk("m_tdata", m_axis_tdata, m_out.d);
            chk("m_tlast", 128'(m_axis_tlast), 128'(m_out.l));
         end
         chk("s_tready", 128'(s_axis_tready), 128'(m_ready));
         chk("fill_level", 128'(fill_level), 128'(pend.size() + comq.size() + int'(m_ov)));
         chk("pkt_avail", 128'(pkt_avail), 128'(m_pkt));
         chk("drop_pulse", 128'(drop_pulse), 128'(m_drop));
`ifdef AXIS_PKT_FIFO_STATS_EN
         chk("drop_count", 128'(drop_count), 128'(m_drops));
         chk("pkt_out_count", 128'(pkt_out_count), 128'(m_outs));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [127:0] d, input bit l);
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
   endtask

   task automatic do_reset();
      drive(0, '0, 0);
      aresetn = 1'b0;
      step();
      step();
      aresetn = 1'b1;
      step();
   endtask

   int     cnt;
   int     rem;
   logic [127:0] rd;

   initial begin
      aresetn = 1'b0;
      #2;
      chk_en = 1'b1;
      step();
      chk("rst tready", 128'(s_axis_tready), 128'(0));
      chk("rst tvalid", 128'(m_axis_tvalid), 128'(0));
      chk("rst tdata", m_axis_tdata, 128'(0));
      chk("rst fill", 128'(fill_level), 128'(0));
      step();
      aresetn = 1'b1;
      step();
      chk("tready after rst", 128'(s_axis_tready), 128'(1));

      // 4-beat packet, sink always ready
      m_axis_tready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(1, 128'(i), i == 4);
         step();
      end
      drive(0, '0, 0);
      chk("lat tvalid early", 128'(m_axis_tvalid), 128'(0));
      chk("pkt_avail 1", 128'(pkt_avail), 128'(1));
      step();
      chk("lat tvalid", 128'(m_axis_tvalid), 128'(1));
      chk("beat1", m_axis_tdata, 128'(1));
      for (int i = 2; i <= 4; i++) begin
         step();
         chk("beat data", m_axis_tdata, 128'(i));
         chk("beat last", 128'(m_axis_tlast), 128'(i == 4));
      end
      step();
      chk("drained tvalid", 128'(m_axis_tvalid), 128'(0));
      chk("pkt_avail 0", 128'(pkt_avail), 128'(0));

      // partial packet stays invisible until its tlast arrives
      for (int i = 0; i < 3; i++) begin
         drive(1, 128'(32'h11 + i), 0);
         step();
      end
      drive(0, '0, 0);
      step();
      chk("partial fill", 128'(fill_level), 128'(3));
      chk("partial tvalid", 128'(m_axis_tvalid), 128'(0));
      drive(1, 128'(32'h14), 1);
      step();
      drive(0, '0, 0);
      step();
      chk("partial release", m_axis_tdata, 128'(32'h11));
      repeat (6) step();

      // overflow with DEPTH=8, sink stalled
      do_reset();
      m_axis_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1, 128'(32'h100 + i), i == 7);
         step();
      end
      for (int j = 0; j < 3; j++) begin
         drive(1, 128'(32'h200 + j), j == 2);
         step();
         if (j == 0) begin
            chk("ovf drop", 128'(drop_pulse), 128'(1));
            chk("ovf fill", 128'(fill_level), 128'(8));
         end else begin
            chk("ovf single pulse", 128'(drop_pulse), 128'(0));
         end
      end
      drive(0, '0, 0);
      step();
      chk("ovf fill hold", 128'(fill_level), 128'(8));
      chk("ovf pkt", 128'(pkt_avail), 128'(1));
`ifdef AXIS_PKT_FIFO_STATS_EN
      chk("ovf drop_count", 128'(drop_count), 128'(1));
`endif
      m_axis_tready = 1'b1;
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         if (m_axis_tvalid) begin
            cnt++;
            chk("ovf only first pkt", 128'(m_axis_tdata[11:8]), 128'(1));
         end
         step();
      end
      chk("ovf beat count", 128'(cnt), 128'(8));

      // back-pressure 1,0,0,1 during a 4-beat packet
      for (int i = 1; i <= 4; i++) begin
         drive(1, 128'(32'h300 + i), i == 4);
         step();
      end
      drive(0, '0, 0);
      step();
      chk("bp b1", m_axis_tdata, 128'(32'h301));
      m_axis_tready = 1'b1; step(); chk("bp b2", m_axis_tdata, 128'(32'h302));
      m_axis_tready = 1'b0; step(); chk("bp hold1", m_axis_tdata, 128'(32'h302));
      m_axis_tready = 1'b0; step(); chk("bp hold2", m_axis_tdata, 128'(32'h302));
      m_axis_tready = 1'b1; step(); chk("bp b3", m_axis_tdata, 128'(32'h303));
      step();
      chk("bp b4", m_axis_tdata, 128'(32'h304));
      chk("bp b4 last", 128'(m_axis_tlast), 128'(1));
      step();
      chk("bp done", 128'(m_axis_tvalid), 128'(0));

      // commit and output-last on the same edge
      drive(1, 128'(32'h401), 0); step();
      drive(1, 128'(32'h402), 1); step();
      drive(0, '0, 0); step();
      step();
      chk("sim pkt before", 128'(pkt_avail), 128'(1));
      drive(1, 128'(32'h4AA), 1); step();
      drive(0, '0, 0);
      chk("sim pkt same", 128'(pkt_avail), 128'(1));
      step();
      chk("sim next pkt", m_axis_tdata, 128'(32'h4AA));
      repeat (3) step();

      // reset mid-packet
      drive(1, 128'(32'h501), 0); step();
      drive(1, 128'(32'h502), 0); step();
      drive(1, 128'(32'h503), 0);
      #2 aresetn = 1'b0;
      #1;
      chk("mid rst tready", 128'(s_axis_tready), 128'(0));
      chk("mid rst fill", 128'(fill_level), 128'(0));
      chk("mid rst tvalid", 128'(m_axis_tvalid), 128'(0));
      step();
      drive(0, '0, 0);
      aresetn = 1'b1;
      step();
      drive(1, 128'(32'hAA), 1); step();
      drive(0, '0, 0); step();
      chk("post rst data", m_axis_tdata, 128'(32'hAA));
      chk("post rst last", 128'(m_axis_tlast), 128'(1));
      step();
      chk("post rst alone", 128'(m_axis_tvalid), 128'(0));

      // random traffic, packet lengths 1..12 so some exceed DEPTH
      rem = 0;
      for (int c = 0; c < 4000 || rem != 0; c++) begin
         m_axis_tready = ($urandom_range(9) < 7);
         if (rem == 0) rem = $urandom_range(12, 1);
         if ($urandom_range(3) != 0) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(7) == 0) rd[127:32] = '0;
            drive(1, rd, rem == 1);
            rem--;
         end else begin
            drive(0, '0, 0);
         end
         step();
      end
      drive(0, '0, 0);
      m_axis_tready = 1'b1;
      repeat (DEPTH + 6) step();
      chk("final pkt_avail", 128'(pkt_avail), 128'(0));
      chk("final fill", 128'(fill_level), 128'(0));
      chk("final tvalid", 128'(m_axis_tvalid), 128'(0));

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/axis_pkt_fifo_128.md
# axis_pkt_fifo_128

Store-and-forward packet FIFO that sits directly downstream of the 32→128 upsizer, between it and the 128-bit command/data consumer. It accepts 128-bit AXI-Stream beats and releases a packet to the output only after that packet's TLAST beat has been written. It never back-pressures the upsizer mid-packet: a packet that would overflow the buffer is dropped whole, and the drop is flagged.

## Interface
- DEPTH, 64, number of 128-bit entries; power of two, minimum 4
- AW, $clog2(DEPTH), pointer width (derived, not overridden)
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  128  input beat
- s_axis_tlast  in  1  last beat of packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  128  output beat, registered
- m_axis_tlast  out  1  output last, registered
- m_axis_tvalid  out  1  output valid, registered
- m_axis_tready  in  1  output ready
- fill_level  out  AW+1  entries written but not yet read, including uncommitted ones
- pkt_avail  out  AW+1  committed packets not yet fully read
- drop_pulse  out  1  one-cycle pulse when a packet is discarded

## Operation
- Storage: DEPTH×129 memory holding {tlast, tdata}. Pointers are AW+1 bits: wr_ptr (tentative), commit_ptr, rd_ptr. Full/empty are decided by comparing the MSBs.
- s_axis_tready is 1 whenever aresetn has been high for at least one cycle. It is 0 during reset.
- Write FSM has two states, ACCEPT and DISCARD.
  - ACCEPT, beat accepted, space available (wr_ptr − rd_ptr < DEPTH): write mem[wr_ptr], then wr_ptr+1.
    - If tlast: commit_ptr ← wr_ptr+1 and pkt_avail+1.
  - ACCEPT, beat accepted, no space: wr_ptr ← commit_ptr and drop_pulse=1.
    - If tlast: stay in ACCEPT.
    - Otherwise: go to DISCARD.
  - DISCARD: accepted beats are ignored. On a beat with tlast, return to ACCEPT with no second pulse.
- Read side: an output register stage with first-word-fall-through behaviour.
  - Load when rd_ptr ≠ commit_ptr and (m_axis_tvalid=0 or m_axis_tready=1).
  - On load, rd_ptr+1.
  - When a beat with tlast=1 leaves the output (tvalid & tready & tlast), pkt_avail−1.
- Simultaneous commit and output-last in one cycle: pkt_avail is unchanged.
- Uncommitted data is never visible at the output.
- Packet order is preserved. Data is not modified; the upsizer's zero padding passes through unchanged.

## Timing
- Reset values: m_axis_tdata=0, m_axis_tlast=0, m_axis_tvalid=0, s_axis_tready=0, fill_level=0, pkt_avail=0, drop_pulse=0. All pointers are 0 and the FSM is in ACCEPT.
- Latency, FIFO and output empty: TLAST beat accepted at edge N → commit at edge N → first beat of the packet valid after edge N+1.
- While tready is held high, throughput is 1 beat/cycle in and 1 beat/cycle out.
- m_axis_tdata and m_axis_tlast are held stable while tvalid=1 and tready=0.
- Reset asserted mid-packet: all state clears asynchronously and partial packets are lost. The first beat after deassertion is treated as the start of a packet.
- A single-beat packet (tlast on its first beat) is legal.
- A packet longer than DEPTH is always dropped.

## Configuration
- AXIS_PKT_FIFO_STATS_EN, when defined, adds:
  - drop_count, out, 32 bits, saturating count of drop_pulse.
  - pkt_out_count, out, 32 bits, saturating count of output TLAST handshakes.
  - Both reset to 0.
- When undefined, these ports and their counters do not exist. All other behaviour is identical.

## Structure
- Shared package axis_pkg holds:
  - localparam AXIS_W128 = 128.
  - The write-FSM enum {WR_ACCEPT, WR_DISCARD}.
  - Counter width STAT_W = 32.
- One sub-module: axis_pkt_fifo_mem, a simple dual-port 129-bit RAM with a synchronous write port and an asynchronous read port.
- Pointer, FSM and output-register logic all live in the top module.

## Test plan
- Reset, then a 4-beat packet with data 0x…01 through 0x…04, last on beat 4, m_axis_tready=1:
  - Output beats match the input in order, tlast on beat 4 only.
  - First output valid 2 cycles after the tlast input.
  - pkt_avail goes 0→1→0.
- Partial packet without tlast: 3 beats written, no tlast.
  - m_axis_tvalid stays 0 and fill_level=3.
  - Sending the 4th beat with tlast releases all 4 beats.
- Overflow, DEPTH=8: an 8-beat packet is held (m_axis_tready=0), then a 3-beat packet is sent.
  - The 3-beat packet overflows: drop_pulse fires once on its first beat, and its remaining beats are discarded.
  - fill_level stays 8.
  - The output then yields only the first packet.
  - With the macro defined, drop_count=1.
- Back-pressure: m_axis_tready toggles 1,0,0,1 during a 4-beat packet.
  - Data stays stable while stalled and no beat is lost or duplicated.
- Simultaneous events: a new packet's tlast is accepted in the same cycle the previous packet's tlast leaves the output.
  - pkt_avail stays 1.
- Reset mid-packet: aresetn is pulled low after 2 of 4 beats.
  - All outputs return to 0 immediately.
  - A following 1-beat packet (data 0xAA) emerges alone with tlast=1.
